// File: rtl/uart_pkg.sv
// Shared UART definitions: line-state encodings used by both TX and RX, and default framing constants.
package uart_pkg;

   localparam int UART_BAUD_DIV = 434;   // 50 MHz / 115200
   localparam int UART_DATA_W   = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   function automatic int uart_frame_clks(input int baud_div, input int stop_bits);
      return (1 + UART_DATA_W + stop_bits) * baud_div;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: one-cycle tick on the last clock of every bit period while enabled.
// Held at zero when disabled; a synchronous clear restarts the period for a new frame.
module uart_baud_tick #(
   parameter int BAUD_DIV = 434
) (
   input  logic clk,
   input  logic n_rst,
   input  logic clr_i,
   input  logic en_i,
   output logic tick_o
);

   localparam int            CW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || !en_i) begin
         cnt_d = '0;
      end else if (cnt_q == LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // The tick must not depend on clr_i: the clear is itself derived from the tick at frame end.
   assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter, 8N1/8N2, LSB first, with a one-entry holding register so the core can
// queue the next byte while a frame is on the wire; back-to-back frames have no idle gap.
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int BAUD_DIV  = UART_BAUD_DIV,
   parameter int STOP_BITS = 1
) (
   input  logic                   clk,
   input  logic                   n_rst,
   input  logic [UART_DATA_W-1:0] tx_data,
   input  logic                   tx_valid,
   output logic                   tx_ready,
   output logic                   txd,
   output logic                   tx_busy,
   output logic                   tx_done
);

   uart_state_e            state_q, state_d;
   logic [UART_DATA_W-1:0] shift_q, shift_d;
   logic [UART_DATA_W-1:0] hold_q, hold_d;
   logic                   hold_full_q, hold_full_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic                   stop_cnt_q, stop_cnt_d;
   logic                   txd_q, txd_d;

   logic tick;
   logic accept;
   logic stop_end;
   logic load;

   uart_baud_tick #(
      .BAUD_DIV (BAUD_DIV)
   ) u_baud (
      .clk    (clk),
      .n_rst  (n_rst),
      .clr_i  (load),
      .en_i   (state_q != IDLE),
      .tick_o (tick)
   );

   assign accept   = tx_valid && !hold_full_q;
   assign stop_end = (state_q == STOP) && tick && (stop_cnt_q == 1'(STOP_BITS - 1));
   assign load     = hold_full_q && ((state_q == IDLE) || stop_end);

   // A byte arriving in the same cycle as a load refills the register just vacated.
   always_comb begin
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      if (load) begin
         hold_full_d = 1'b0;
      end
      if (accept) begin
         hold_d      = tx_data;
         hold_full_d = 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      txd_d      = txd_q;
      case (state_q)
         IDLE: begin
            txd_d = 1'b1;
            if (load) begin
               state_d    = START;
               shift_d    = hold_q;
               bit_cnt_d  = 3'd0;
               stop_cnt_d = 1'b0;
               txd_d      = 1'b0;
            end
         end
         START: begin
            if (tick) begin
               state_d = DATA;
               txd_d   = shift_q[0];
            end
         end
         DATA: begin
            if (tick) begin
               if (bit_cnt_q == 3'd7) begin
                  state_d    = STOP;
                  stop_cnt_d = 1'b0;
                  txd_d      = 1'b1;
               end else begin
                  shift_d   = {1'b0, shift_q[UART_DATA_W-1:1]};
                  txd_d     = shift_q[1];
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         STOP: begin
            if (stop_end) begin
               if (load) begin
                  state_d    = START;
                  shift_d    = hold_q;
                  bit_cnt_d  = 3'd0;
                  stop_cnt_d = 1'b0;
                  txd_d      = 1'b0;
               end else begin
                  state_d = IDLE;
                  txd_d   = 1'b1;
               end
            end else if (tick) begin
               stop_cnt_d = stop_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            txd_d   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         bit_cnt_q   <= 3'd0;
         stop_cnt_q  <= 1'b0;
         txd_q       <= 1'b1;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         bit_cnt_q   <= bit_cnt_d;
         stop_cnt_q  <= stop_cnt_d;
         txd_q       <= txd_d;
      end
   end

   assign tx_ready = !hold_full_q;
   assign txd      = txd_q;
   assign tx_busy  = (state_q != IDLE);
   assign tx_done  = stop_end;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: frame-level reference model compared every cycle on a BAUD_DIV=4 8N1
// instance, plus directed literal checks and an 8N2 @ 434 instance decoded by a line sampler.
module tb_uart_tx_frame;
   import uart_pkg::*;

   localparam int DIV  = 4;
   localparam int LEN  = (1 + 8 + 1) * DIV;
   localparam int DIV2 = 434;
   localparam int LEN2 = (1 + 8 + 2) * DIV2;

   logic       clk = 1'b0;
   logic       n_rst;
   logic [7:0] tx_data, tx_data2;
   logic       tx_valid, tx_valid2;
   logic       tx_ready, txd, tx_busy, tx_done;
   logic       tx_ready2, txd2, tx_busy2, tx_done2;

   always #5 clk = ~clk;

   uart_tx_frame #(.BAUD_DIV(DIV), .STOP_BITS(1)) dut (
      .clk(clk), .n_rst(n_rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .txd(txd), .tx_busy(tx_busy), .tx_done(tx_done));

   uart_tx_frame #(.BAUD_DIV(DIV2), .STOP_BITS(2)) dut2 (
      .clk(clk), .n_rst(n_rst), .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
      .txd(txd2), .tx_busy(tx_busy2), .tx_done(tx_done2));

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int acc_cyc;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic chkn(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Reference: a frame is a 12-bit line image (start, data LSB first, stop ones) played one bit
   // per DIV clocks; a held byte starts the next frame the clock after the previous one ends.
   bit         m_busy  = 1'b0;
   bit         m_hfull = 1'b0;
   int         m_t     = 0;
   logic [7:0] m_hold  = '0;
   logic [11:0] m_frame = '1;
   bit         m_acc, m_last, m_ld;

   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         m_busy  = 1'b0;
         m_hfull = 1'b0;
         m_t     = 0;
      end else begin
         m_acc  = (tx_valid === 1'b1) && !m_hfull;
         m_last = m_busy && (m_t == LEN - 1);
         m_ld   = m_hfull && (!m_busy || m_last);
         if (m_busy) begin
            if (m_last) m_busy = 1'b0;
            else        m_t    = m_t + 1;
         end
         if (m_ld) begin
            m_busy  = 1'b1;
            m_t     = 0;
            m_frame = {3'b111, m_hold, 1'b0};
         end
         m_hfull = (m_hfull && !m_ld) || m_acc;
         if (m_acc) m_hold = tx_data;
      end
   end

   always @(negedge clk) begin
      chk1("txd",      txd,      m_busy ? m_frame[m_t / DIV] : 1'b1);
      chk1("tx_busy",  tx_busy,  m_busy);
      chk1("tx_done",  tx_done,  m_busy && (m_t == LEN - 1));
      chk1("tx_ready", tx_ready, !m_hfull);
   end

   // Line sampler for the DIV=4 instance: samples each bit mid-period.
   int dec_q[$];
   int start_q[$];
   int done_q[$];
   bit dec_in = 1'b0;
   int dec_i  = 0;
   int dec_b  = 0;

   always @(negedge clk) begin
      if (n_rst !== 1'b1) begin
         dec_in = 1'b0;
      end else begin
         if (dec_in) dec_i++;
         else if (txd === 1'b0) begin
            dec_in = 1'b1;
            dec_i  = 0;
            dec_b  = 0;
            start_q.push_back(cyc);
         end
         if (dec_in) begin
            if ((dec_i % DIV == DIV / 2) && (dec_i / DIV >= 1) && (dec_i / DIV <= 8))
               dec_b[dec_i / DIV - 1] = txd;
            if (dec_i == LEN - 1) begin
               dec_q.push_back(dec_b);
               dec_in = 1'b0;
            end
         end
         if (tx_done === 1'b1) done_q.push_back(cyc);
      end
   end

   function automatic int qget(input int q[$], input int i);
      if (i >= 0 && i < q.size()) return q[i];
      return -1;
   endfunction

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [7:0] b, input bit keep);
      bit hs;
      hs       = 1'b0;
      tx_data  = b;
      tx_valid = 1'b1;
      for (int n = 0; n < 200 && !hs; n++) begin
         @(negedge clk);
         hs = tx_ready;
         @(posedge clk);
      end
      #1;
      acc_cyc = cyc;
      chk1("send_accept", hs, 1'b1);
      if (!keep) tx_valid = 1'b0;
   endtask

   task automatic send2(input logic [7:0] b);
      bit hs;
      hs        = 1'b0;
      tx_data2  = b;
      tx_valid2 = 1'b1;
      for (int n = 0; n < 200 && !hs; n++) begin
         @(negedge clk);
         hs = tx_ready2;
         @(posedge clk);
      end
      #1;
      chk1("send2_accept", hs, 1'b1);
      tx_valid2 = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget);
      for (int n = 0; n < budget && done_q.size() < target; n++) @(negedge clk);
      chkn("done_count", done_q.size(), target);
   endtask

   logic lvl [0:LEN2+25];

   initial begin : main
      int s, k, done2, low_len, b2;
      logic busy_last, busy_after;
      n_rst     = 1'b0;
      tx_data   = '0;
      tx_valid  = 1'b0;
      tx_data2  = '0;
      tx_valid2 = 1'b0;
      repeat (3) @(posedge clk);
      #2 n_rst = 1'b1;

      // Idle after reset
      repeat (100) @(posedge clk);
      #1;
      chk1("t1_txd", txd, 1'b1);
      chk1("t1_ready", tx_ready, 1'b1);
      chk1("t1_busy", tx_busy, 1'b0);

      // Single byte 0xA5: start bit is on the line in the clock after the load edge
      send(8'hA5, 1'b0);
      wait_done(1, 100);
      chkn("t2_byte", qget(dec_q, 0), 32'hA5);
      chkn("t2_latency", qget(start_q, 0) - acc_cyc, 1);
      chkn("t2_done_at", qget(done_q, 0) - qget(start_q, 0), LEN - 1);

      // Second byte queued mid-frame
      @(posedge clk); #1;
      send(8'h55, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      send(8'h0F, 1'b0);
      chk1("t3_ready_low", tx_ready, 1'b0);
      wait_done(3, 200);
      chkn("t3_byte0", qget(dec_q, 1), 32'h55);
      chkn("t3_byte1", qget(dec_q, 2), 32'h0F);
      chkn("t3_no_gap", qget(start_q, 2) - qget(start_q, 1), LEN);

      // tx_valid held across three bytes
      @(posedge clk); #1;
      send(8'h01, 1'b1);
      send(8'h02, 1'b1);
      send(8'h03, 1'b0);
      wait_done(6, 400);
      repeat (50) @(posedge clk);
      #1;
      chkn("t4_frames", dec_q.size(), 6);
      chkn("t4_byte0", qget(dec_q, 3), 1);
      chkn("t4_byte1", qget(dec_q, 4), 2);
      chkn("t4_byte2", qget(dec_q, 5), 3);
      chkn("t4_gap01", qget(start_q, 4) - qget(start_q, 3), LEN);
      chkn("t4_gap12", qget(start_q, 5) - qget(start_q, 4), LEN);

      // Reset during data bit 4 of a 0x00 frame
      @(posedge clk); #1;
      send(8'h00, 1'b0);
      for (k = 0; k < 200 && start_q.size() < 7; k++) @(negedge clk);
      chkn("t5_started", start_q.size(), 7);
      s = qget(start_q, 6);
      while (cyc < s + 21) begin
         @(posedge clk);
         #2;
      end
      chk1("t5_pre_txd", txd, 1'b0);
      n_rst = 1'b0;
      #1;
      chk1("t5_txd_async", txd, 1'b1);
      chk1("t5_busy", tx_busy, 1'b0);
      chk1("t5_ready", tx_ready, 1'b1);
      repeat (3) @(posedge clk);
      #2 n_rst = 1'b1;
      repeat (60) @(posedge clk);
      #1;
      chkn("t5_no_done", done_q.size(), 6);
      chkn("t5_no_frame", dec_q.size(), 6);
      chkn("t5_no_restart", start_q.size(), 7);

      // 8N2 at 434 clocks per bit
      @(posedge clk); #1;
      send2(8'h00);
      for (k = 0; k < 100 && txd2 !== 1'b0; k++) @(negedge clk);
      chk1("t6_start", txd2, 1'b0);
      done2      = -1;
      busy_last  = 1'b0;
      busy_after = 1'b1;
      for (k = 0; k <= LEN2 + 25; k++) begin
         lvl[k] = txd2;
         if (tx_done2 === 1'b1 && done2 < 0) done2 = k;
         if (k == LEN2 - 1) busy_last = tx_busy2;
         if (k == LEN2) busy_after = tx_busy2;
         @(negedge clk);
      end
      low_len = 0;
      while (low_len <= LEN2 && lvl[low_len] === 1'b0) low_len++;
      chkn("t6_low_run", low_len, 9 * DIV2);
      k = low_len;
      while (k <= LEN2 + 25 && lvl[k] === 1'b1) k++;
      chkn("t6_high_run_to_end", k - low_len, LEN2 + 26 - low_len);
      chkn("t6_stop_len", done2 - low_len + 1, 2 * DIV2);
      chkn("t6_frame_len", done2 + 1, 4774);
      b2 = 0;
      for (int j = 0; j < 8; j++) b2[j] = lvl[DIV2 * (j + 1) + DIV2 / 2];
      chkn("t6_loopback", b2, 0);
      chk1("t6_busy_last", busy_last, 1'b1);
      chk1("t6_busy_after", busy_after, 1'b0);
      chk1("t6_ready", tx_ready2, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
